// File: rtl/axi_ocp_rw_sched_pkg.sv
// Shared types for the AXI-to-OCP burst scheduler: OCP/AXI encodings and scheduler states.
package axi_ocp_pkg;

   typedef enum logic [2:0] {
      OCP_CMD_IDLE = 3'd0,
      OCP_CMD_WR   = 3'd1,
      OCP_CMD_RD   = 3'd2
   } ocp_cmd_e;

   typedef enum logic [1:0] {
      OCP_RESP_NULL = 2'd0,
      OCP_RESP_DVA  = 2'd1,
      OCP_RESP_FAIL = 2'd2,
      OCP_RESP_ERR  = 2'd3
   } ocp_resp_e;

   typedef enum logic [1:0] {
      AXI_RESP_OKAY   = 2'b00,
      AXI_RESP_EXOKAY = 2'b01,
      AXI_RESP_SLVERR = 2'b10,
      AXI_RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_CMD  = 3'd1,
      ST_WR_DATA = 3'd2,
      ST_WR_RESP = 3'd3,
      ST_RD_CMD  = 3'd4,
      ST_RD_DATA = 3'd5
   } sched_state_e;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_SLVERR = 2'b10;

   // Arbiter request/grant bit positions.
   localparam int GNT_WR = 0;
   localparam int GNT_RD = 1;

   // Anything other than DVA is reported to the AXI master as a slave error.
   function automatic logic [1:0] map_resp(input logic [1:0] sresp);
      return (sresp == OCP_RESP_DVA) ? AXI_OKAY : AXI_SLVERR;
   endfunction

endpackage

// File: rtl/axi_ocp_rw_sched_arb.sv
// Two-requester round-robin arbiter with a one-hot grant; bit 0 is write, bit 1 is read.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   logic prefer_rd;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) begin
            gnt = prefer_rd ? 2'b10 : 2'b01;
         end else begin
            gnt = req;
         end
      end
   end

   // A grant is always accepted in the same cycle, so the pointer moves on every grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         prefer_rd <= 1'b0;
      end else if (|gnt) begin
         prefer_rd <= gnt[0];
      end
   end

endmodule

// File: rtl/axi_ocp_rw_sched.sv
// Schedules AXI read/write bursts onto one OCP master port, one burst in flight at a time.
module axi_ocp_rw_sched
   import axi_ocp_pkg::*;
#(
   parameter int IDW  = 4,
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int LENW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IDW-1:0]  awid,
   input  logic [AW-1:0]   awaddr,
   input  logic [LENW-1:0] awlen,
   input  logic            awvalid,
   output logic            awready,
   input  logic [DW-1:0]   wdata,
   input  logic            wlast,
   input  logic            wvalid,
   output logic            wready,
   output logic [IDW-1:0]  bid,
   output logic [1:0]      bresp,
   output logic            bvalid,
   input  logic            bready,
   input  logic [IDW-1:0]  arid,
   input  logic [AW-1:0]   araddr,
   input  logic [LENW-1:0] arlen,
   input  logic            arvalid,
   output logic            arready,
   output logic [IDW-1:0]  rid,
   output logic [DW-1:0]   rdata,
   output logic [1:0]      rresp,
   output logic            rlast,
   output logic            rvalid,
   input  logic            rready,
   output logic [2:0]      MCmd,
   output logic [AW-1:0]   MAddr,
   output logic [LENW-1:0] MBurstLength,
   output logic [IDW-1:0]  MTagID,
   output logic            MDataValid,
   output logic [DW-1:0]   MData,
   output logic            MDataLast,
   output logic            MRespAccept,
   input  logic            SCmdAccept,
   input  logic            SDataAccept,
   input  logic [1:0]      SResp,
   input  logic [DW-1:0]   SData,
   input  logic            SRespLast,
   input  logic [IDW-1:0]  STagID,
   output logic            proto_err,
   output sched_state_e    state
);

   // Valid/ready: a transfer happens on a cycle where both are high; valid never waits on ready.
   sched_state_e    state_q, state_d;
   logic [IDW-1:0]  tag_q;
   logic [AW-1:0]   addr_q;
   logic [LENW-1:0] len_q;
   logic [LENW:0]   cnt_q;
   logic            perr_q;
   logic [1:0]      gnt;
   logic            arb_en;
   logic            beat_acc;
   logic            last_beat;
   logic            resp_valid;
   logic            stag_unused;

   // Only one burst is ever outstanding, so the returned tag carries no information.
   assign stag_unused = ^STagID;

   assign arb_en     = (state_q == ST_IDLE) && !rst;
   assign beat_acc   = (state_q == ST_WR_DATA) && wvalid && SDataAccept;
   assign last_beat  = (state_q == ST_WR_DATA) && (cnt_q == {1'b0, len_q});
   assign resp_valid = (SResp != OCP_RESP_NULL);
   assign proto_err  = perr_q;
   assign state      = state_q;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({arvalid, awvalid}),
      .en  (arb_en),
      .gnt (gnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q  <= '0;
         addr_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
         perr_q <= 1'b0;
      end else begin
         if (gnt[GNT_WR]) begin
            tag_q  <= awid;
            addr_q <= awaddr;
            len_q  <= awlen;
         end else if (gnt[GNT_RD]) begin
            tag_q  <= arid;
            addr_q <= araddr;
            len_q  <= arlen;
         end
         if (state_q == ST_IDLE) begin
            cnt_q <= '0;
         end else if (beat_acc) begin
            cnt_q <= cnt_q + (LENW+1)'(1);
         end
         // The beat count is authoritative; a disagreeing wlast is only flagged.
         perr_q <= beat_acc && (wlast != last_beat);
      end
   end

   always_comb begin
      state_d      = state_q;
      awready      = 1'b0;
      arready      = 1'b0;
      wready       = 1'b0;
      bid          = '0;
      bresp        = AXI_OKAY;
      bvalid       = 1'b0;
      rid          = '0;
      rdata        = '0;
      rresp        = AXI_OKAY;
      rlast        = 1'b0;
      rvalid       = 1'b0;
      MCmd         = OCP_CMD_IDLE;
      MAddr        = '0;
      MBurstLength = '0;
      MTagID       = '0;
      MDataValid   = 1'b0;
      MData        = '0;
      MDataLast    = 1'b0;
      MRespAccept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            awready = gnt[GNT_WR];
            arready = gnt[GNT_RD];
            if (gnt[GNT_WR]) begin
               state_d = ST_WR_CMD;
            end else if (gnt[GNT_RD]) begin
               state_d = ST_RD_CMD;
            end
         end
         ST_WR_CMD, ST_RD_CMD: begin
            MCmd         = (state_q == ST_WR_CMD) ? OCP_CMD_WR : OCP_CMD_RD;
            MAddr        = addr_q;
            MBurstLength = len_q;
            MTagID       = tag_q;
            if (SCmdAccept) begin
               state_d = (state_q == ST_WR_CMD) ? ST_WR_DATA : ST_RD_DATA;
            end
         end
         ST_WR_DATA: begin
            MDataValid = wvalid;
            MData      = wdata;
            wready     = SDataAccept;
            MDataLast  = last_beat;
            if (beat_acc && last_beat) begin
               state_d = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            bvalid      = resp_valid;
            bid         = tag_q;
            bresp       = resp_valid ? map_resp(SResp) : AXI_OKAY;
            MRespAccept = bready;
            if (resp_valid && bready) begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_DATA: begin
            rvalid      = resp_valid;
            rdata       = SData;
            rlast       = SRespLast;
            rid         = tag_q;
            rresp       = resp_valid ? map_resp(SResp) : AXI_OKAY;
            MRespAccept = rready;
            if (resp_valid && rready && SRespLast) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_axi_ocp_rw_sched.sv
// Directed bench for axi_ocp_rw_sched: per-cycle vector table plus hand-written multi-cycle cases.
module tb_axi_ocp_rw_sched;
   import axi_ocp_pkg::*;

   localparam logic [31:0] AWADDR = 32'h1000_0040;
   localparam logic [31:0] ARADDR = 32'h2000_0080;
   localparam logic [3:0]  AWID   = 4'h3;
   localparam logic [3:0]  ARID   = 4'h5;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  awid, arid, bid, rid, MTagID, STagID;
   logic [31:0] awaddr, araddr, wdata, rdata, MAddr, MData, SData;
   logic [3:0]  awlen, arlen, MBurstLength;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [1:0]  bresp, rresp, SResp;
   logic [2:0]  MCmd;
   logic        MDataValid, MDataLast, MRespAccept, SCmdAccept, SDataAccept, SRespLast;
   logic        proto_err;
   sched_state_e state;

   int n_vec = 0;
   int n_err = 0;

   axi_ocp_rw_sched dut (
      .clk(clk), .rst(rst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .MCmd(MCmd), .MAddr(MAddr), .MBurstLength(MBurstLength), .MTagID(MTagID),
      .MDataValid(MDataValid), .MData(MData), .MDataLast(MDataLast), .MRespAccept(MRespAccept),
      .SCmdAccept(SCmdAccept), .SDataAccept(SDataAccept),
      .SResp(SResp), .SData(SData), .SRespLast(SRespLast), .STagID(STagID),
      .proto_err(proto_err), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
      $fatal(1);
   end

   typedef struct {
      string       name;
      logic        awvalid, arvalid, wvalid, wlast, bready, rready, cmd_acc, data_acc, slast;
      logic [3:0]  len;
      logic [1:0]  sresp;
      logic [31:0] wdata, sdata;
      logic        exp_awready, exp_arready;
      logic [2:0]  exp_mcmd;
      logic        exp_mdv, exp_mdlast, exp_wready, exp_bvalid;
      logic [1:0]  exp_bresp;
      logic        exp_rvalid;
      logic [1:0]  exp_rresp;
      logic        exp_rlast;
      logic [31:0] exp_rdata;
      logic        exp_mracc, exp_perr;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      awid = '0; awaddr = '0; awlen = '0; awvalid = 0;
      wdata = '0; wlast = 0; wvalid = 0; bready = 0;
      arid = '0; araddr = '0; arlen = '0; arvalid = 0; rready = 0;
      SCmdAccept = 0; SDataAccept = 0; SResp = OCP_RESP_NULL; SData = '0;
      SRespLast = 0; STagID = '0;
   endtask

   function automatic vec_t nv(input string name);
      vec_t v;
      v.name = name;
      v.awvalid = 0; v.arvalid = 0; v.wvalid = 0; v.wlast = 0; v.bready = 0; v.rready = 0;
      v.cmd_acc = 0; v.data_acc = 0; v.slast = 0; v.len = '0; v.sresp = OCP_RESP_NULL;
      v.wdata = '0; v.sdata = '0;
      v.exp_awready = 0; v.exp_arready = 0; v.exp_mcmd = 3'd0;
      v.exp_mdv = 0; v.exp_mdlast = 0; v.exp_wready = 0; v.exp_bvalid = 0; v.exp_bresp = 2'b00;
      v.exp_rvalid = 0; v.exp_rresp = 2'b00; v.exp_rlast = 0; v.exp_rdata = '0;
      v.exp_mracc = 0; v.exp_perr = 0;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      awid = AWID; awaddr = AWADDR; awlen = v.len; awvalid = v.awvalid;
      arid = ARID; araddr = ARADDR; arlen = v.len; arvalid = v.arvalid;
      wvalid = v.wvalid; wlast = v.wlast; wdata = v.wdata;
      bready = v.bready; rready = v.rready;
      SCmdAccept = v.cmd_acc; SDataAccept = v.data_acc;
      SResp = v.sresp; SData = v.sdata; SRespLast = v.slast; STagID = 4'hF;
   endtask

   task automatic check_vec(input vec_t v);
      logic [31:0] exp_addr;
      logic [3:0]  exp_tag;
      exp_addr = (v.exp_mcmd == 3'd1) ? AWADDR : (v.exp_mcmd == 3'd2) ? ARADDR : 32'h0;
      exp_tag  = (v.exp_mcmd == 3'd1) ? AWID : (v.exp_mcmd == 3'd2) ? ARID : 4'h0;
      chk({v.name, ".awready"},     awready,     v.exp_awready);
      chk({v.name, ".arready"},     arready,     v.exp_arready);
      chk({v.name, ".MCmd"},        MCmd,        v.exp_mcmd);
      chk({v.name, ".MAddr"},       MAddr,       exp_addr);
      chk({v.name, ".MTagID"},      MTagID,      exp_tag);
      chk({v.name, ".MDataValid"},  MDataValid,  v.exp_mdv);
      chk({v.name, ".MData"},       MData,       v.exp_mdv ? v.wdata : 32'h0);
      chk({v.name, ".MDataLast"},   MDataLast,   v.exp_mdlast);
      chk({v.name, ".wready"},      wready,      v.exp_wready);
      chk({v.name, ".bvalid"},      bvalid,      v.exp_bvalid);
      chk({v.name, ".rvalid"},      rvalid,      v.exp_rvalid);
      chk({v.name, ".rlast"},       rlast,       v.exp_rlast);
      chk({v.name, ".MRespAccept"}, MRespAccept, v.exp_mracc);
      chk({v.name, ".proto_err"},   proto_err,   v.exp_perr);
      if (v.exp_bvalid) begin
         chk({v.name, ".bresp"}, bresp, v.exp_bresp);
         chk({v.name, ".bid"},   bid,   AWID);
      end
      if (v.exp_rvalid) begin
         chk({v.name, ".rresp"}, rresp, v.exp_rresp);
         chk({v.name, ".rdata"}, rdata, v.exp_rdata);
         chk({v.name, ".rid"},   rid,   ARID);
      end
   endtask

   task automatic build_table();
      vec_t v;
      // Write, awlen=3, one data stall after beat 0, one NULL response cycle.
      v = nv("w1_grant"); v.awvalid = 1; v.len = 4'd3; v.cmd_acc = 1; v.data_acc = 1;
      v.exp_awready = 1; tbl.push_back(v);
      v = nv("w1_cmd"); v.cmd_acc = 1; v.data_acc = 1; v.exp_mcmd = 3'd1; tbl.push_back(v);
      for (int b = 0; b < 4; b++) begin
         if (b == 1) begin
            v = nv("w1_stall"); v.wvalid = 1; v.wdata = 32'hD000_0001; v.cmd_acc = 1;
            v.exp_mdv = 1; tbl.push_back(v);
         end
         v = nv($sformatf("w1_beat%0d", b)); v.wvalid = 1; v.wdata = 32'hD000_0000 + b;
         v.cmd_acc = 1; v.data_acc = 1; v.wlast = (b == 3);
         v.exp_mdv = 1; v.exp_wready = 1; v.exp_mdlast = (b == 3); tbl.push_back(v);
      end
      v = nv("w1_nullresp"); v.bready = 1; v.exp_mracc = 1; tbl.push_back(v);
      v = nv("w1_resp"); v.bready = 1; v.sresp = OCP_RESP_DVA;
      v.exp_bvalid = 1; v.exp_bresp = 2'b00; v.exp_mracc = 1; tbl.push_back(v);
      v = nv("w1_done"); v.cmd_acc = 1; v.data_acc = 1; tbl.push_back(v);
      // Read, arlen=0, one NULL cycle and one rready stall.
      v = nv("r1_grant"); v.arvalid = 1; v.exp_arready = 1; tbl.push_back(v);
      v = nv("r1_cmd"); v.cmd_acc = 1; v.exp_mcmd = 3'd2; tbl.push_back(v);
      v = nv("r1_null"); v.rready = 1; v.exp_mracc = 1; tbl.push_back(v);
      v = nv("r1_stall"); v.sresp = OCP_RESP_DVA; v.sdata = 32'hA5A5_0001; v.slast = 1;
      v.exp_rvalid = 1; v.exp_rdata = 32'hA5A5_0001; v.exp_rlast = 1; tbl.push_back(v);
      v = nv("r1_data"); v.sresp = OCP_RESP_DVA; v.sdata = 32'hA5A5_0001; v.slast = 1;
      v.rready = 1; v.exp_rvalid = 1; v.exp_rdata = 32'hA5A5_0001; v.exp_rlast = 1;
      v.exp_mracc = 1; tbl.push_back(v);
      v = nv("r1_done"); tbl.push_back(v);
      // Single-beat write answered with FAIL.
      v = nv("w2_grant"); v.awvalid = 1; v.exp_awready = 1; tbl.push_back(v);
      v = nv("w2_cmd"); v.cmd_acc = 1; v.exp_mcmd = 3'd1; tbl.push_back(v);
      v = nv("w2_beat"); v.wvalid = 1; v.wlast = 1; v.wdata = 32'hBEEF_0000; v.data_acc = 1;
      v.exp_mdv = 1; v.exp_wready = 1; v.exp_mdlast = 1; tbl.push_back(v);
      v = nv("w2_resp"); v.bready = 1; v.sresp = OCP_RESP_FAIL;
      v.exp_bvalid = 1; v.exp_bresp = 2'b10; v.exp_mracc = 1; tbl.push_back(v);
      // Read answered with ERR.
      v = nv("r2_grant"); v.arvalid = 1; v.exp_arready = 1; tbl.push_back(v);
      v = nv("r2_cmd"); v.cmd_acc = 1; v.exp_mcmd = 3'd2; tbl.push_back(v);
      v = nv("r2_data"); v.sresp = OCP_RESP_ERR; v.sdata = 32'h0000_0BAD; v.slast = 1;
      v.rready = 1; v.exp_rvalid = 1; v.exp_rresp = 2'b10; v.exp_rdata = 32'h0000_0BAD;
      v.exp_rlast = 1; v.exp_mracc = 1; tbl.push_back(v);
      v = nv("r2_done"); tbl.push_back(v);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".awready"},     awready,     0);
      chk({tag, ".arready"},     arready,     0);
      chk({tag, ".MCmd"},        MCmd,        0);
      chk({tag, ".MAddr"},       MAddr,       0);
      chk({tag, ".MDataValid"},  MDataValid,  0);
      chk({tag, ".MDataLast"},   MDataLast,   0);
      chk({tag, ".wready"},      wready,      0);
      chk({tag, ".bvalid"},      bvalid,      0);
      chk({tag, ".rvalid"},      rvalid,      0);
      chk({tag, ".MRespAccept"}, MRespAccept, 0);
      chk({tag, ".proto_err"},   proto_err,   0);
   endtask

   initial begin
      logic [0:0] exp_q[$];
      logic [0:0] got_q[$];
      int         gcyc[$];
      int         exp_gap[$];

      idle_inputs();
      rst = 1;
      // Reset with requests pending: nothing may be granted or driven.
      awvalid = 1; arvalid = 1; SDataAccept = 1; SCmdAccept = 1; SResp = OCP_RESP_DVA;
      repeat (2) @(negedge clk);
      #1 chk_all_zero("reset");
      @(negedge clk);
      rst = 0;
      idle_inputs();

      build_table();
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         #1 check_vec(tbl[i]);
         @(negedge clk);
      end

      // Both sides requesting continuously: last grant was a read, so W,R,W,R.
      idle_inputs();
      exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_gap = '{4, 3, 4};
      awvalid = 1; arvalid = 1; awid = AWID; awaddr = AWADDR; arid = ARID; araddr = ARADDR;
      SCmdAccept = 1; SDataAccept = 1; wvalid = 1; wlast = 1; bready = 1; rready = 1;
      SResp = OCP_RESP_DVA; SRespLast = 1;
      for (int c = 0; c < 60 && got_q.size() < 4; c++) begin
         #1;
         if (awready) begin got_q.push_back(1'b0); gcyc.push_back(c); end
         if (arready) begin got_q.push_back(1'b1); gcyc.push_back(c); end
         @(negedge clk);
      end
      awvalid = 0; arvalid = 0;
      chk("alt.grant_count", got_q.size(), 4);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
         chk($sformatf("alt.grant%0d_is_rd", i), got_q[i], exp_q[i]);
      for (int i = 0; i < 3 && i + 1 < gcyc.size(); i++)
         chk($sformatf("alt.gap%0d", i), gcyc[i+1] - gcyc[i], exp_gap[i]);
      repeat (3) @(negedge clk);
      idle_inputs();
      #1 chk("alt.settled_mcmd", MCmd, 0);
      @(negedge clk);

      // Command held while SCmdAccept is low, then bready held low on the response.
      awvalid = 1; awid = 4'h9; awaddr = 32'hCAFE_0010; awlen = 4'd0;
      #1 chk("cmdstall.awready", awready, 1);
      @(negedge clk);
      awvalid = 0; awaddr = 32'h0; awid = 4'h0;
      for (int k = 0; k < 4; k++) begin
         SCmdAccept = (k == 3);
         #1;
         chk($sformatf("cmdstall.MCmd%0d", k),   MCmd,   3'd1);
         chk($sformatf("cmdstall.MAddr%0d", k),  MAddr,  32'hCAFE_0010);
         chk($sformatf("cmdstall.MTagID%0d", k), MTagID, 4'h9);
         @(negedge clk);
      end
      SCmdAccept = 0; wvalid = 1; wlast = 1; wdata = 32'h0000_1234; SDataAccept = 1;
      #1 chk("cmdstall.MDataLast", MDataLast, 1);
      @(negedge clk);
      wvalid = 0; wlast = 0; SDataAccept = 0; SResp = OCP_RESP_DVA; bready = 0;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk($sformatf("bstall.bvalid%0d", k),      bvalid,      1);
         chk($sformatf("bstall.MRespAccept%0d", k), MRespAccept, 0);
         chk($sformatf("bstall.bid%0d", k),         bid,         4'h9);
         @(negedge clk);
      end
      bready = 1;
      #1 chk("bstall.MRespAccept_go", MRespAccept, 1);
      @(negedge clk);
      idle_inputs();
      #1 chk("bstall.done_bvalid", bvalid, 0);
      @(negedge clk);

      // Early wlast on a two-beat write: flagged, but MDataLast follows the count.
      awvalid = 1; awid = 4'h2; awaddr = 32'h0000_0100; awlen = 4'd1;
      @(negedge clk);
      awvalid = 0; SCmdAccept = 1;
      #1 chk("perr.MBurstLength", MBurstLength, 4'd1);
      @(negedge clk);
      SCmdAccept = 0; SDataAccept = 1; wvalid = 1; wlast = 1; wdata = 32'h0000_00A1;
      #1 chk("perr.beat1_MDataLast", MDataLast, 0);
      chk("perr.beat1_proto_err", proto_err, 0);
      @(negedge clk);
      wdata = 32'h0000_00A2;
      #1 chk("perr.beat2_MDataLast", MDataLast, 1);
      chk("perr.beat2_proto_err", proto_err, 1);
      @(negedge clk);
      wvalid = 0; wlast = 0; SDataAccept = 0; SResp = OCP_RESP_DVA; bready = 1;
      #1 chk("perr.resp_proto_err", proto_err, 0);
      chk("perr.resp_bvalid", bvalid, 1);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);

      // Reset in the middle of a write burst, then an ordinary read.
      awvalid = 1; awid = 4'h1; awaddr = 32'h0000_0200; awlen = 4'd3;
      @(negedge clk);
      awvalid = 0; SCmdAccept = 1;
      @(negedge clk);
      wvalid = 1; wlast = 0; wdata = 32'h0000_0B01; SDataAccept = 1;
      #1 chk("rstmid.in_data", MDataValid, 1);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0; SResp = OCP_RESP_DVA;
      #1 chk_all_zero("rstmid.after");
      wvalid = 0; SResp = OCP_RESP_NULL;
      arvalid = 1; arid = 4'h6; araddr = 32'h3000_0004; arlen = 4'd0;
      #1 chk("rstmid.arready", arready, 1);
      @(negedge clk);
      arvalid = 0;
      #1 chk("rstmid.MCmd", MCmd, 3'd2);
      chk("rstmid.MAddr", MAddr, 32'h3000_0004);
      @(negedge clk);
      SCmdAccept = 0; SResp = OCP_RESP_DVA; SData = 32'h0000_0077; SRespLast = 1; rready = 1;
      #1 chk("rstmid.rvalid", rvalid, 1);
      chk("rstmid.rdata", rdata, 32'h0000_0077);
      chk("rstmid.rid", rid, 4'h6);
      @(negedge clk);
      idle_inputs();
      #1 chk("rstmid.final_rvalid", rvalid, 0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
